// File: rtl/spdif_tx.sv
// spdif_tx -- S/PDIF (IEC 60958) biphase-mark transmitter.
// One en_i pulse advances one biphase cell (Fs*128). A frame is 128 cells:
// left subframe in cells 0..63, right in 64..127, 32 slots of 2 cells each.
// Optional feature: define SPDIF_TX_CHSTAT_EN to send CHSTAT bits 0..23 in
// the C slot of frames 0..23; otherwise the C slot is always 0.
//
// pcm_rd_o is a combinational strobe: high during the clock in which en_i
// starts cell 0. pcm_l_i/pcm_r_i are captured on the rising edge that ends
// that clock, so the sample source must present its data alongside the strobe.
module spdif_tx #(
    parameter int          DAT_W  = 24,
    parameter logic [23:0] CHSTAT = 24'h000200
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DAT_W-1:0] pcm_l_i,
    input  logic [DAT_W-1:0] pcm_r_i,
    output logic             pcm_rd_o,
    output logic             spdif_o
);

    // Preambles as seen with a low line before their first cell, first cell in bit 7.
    localparam logic [7:0] PRE_B = 8'hE8;
    localparam logic [7:0] PRE_M = 8'hE2;
    localparam logic [7:0] PRE_W = 8'hE4;
    // Samples narrower than 24 bits are MSB-aligned to slot 27.
    localparam int PAD = 24 - DAT_W;

    logic [6:0]       cell_q;
    logic [7:0]       frame_q;
    logic [DAT_W-1:0] shd_l_q;
    logic [DAT_W-1:0] shd_r_q;
    logic             par_q,     par_d;
    logic             pre_inv_q, pre_inv_d;
    logic             spdif_q,   spdif_d;

    logic [4:0]  slot;
    logic        right;
    logic        sub_start;
    logic [23:0] samp24;
    logic        c_bit;
    logic        slot_bit;
    logic [7:0]  pre_sel;
    logic        pre_lvl;

    assign slot      = cell_q[5:1];
    assign right     = cell_q[6];
    assign sub_start = (cell_q[5:0] == 6'd0);

    // Sample strobe lives in the same clock as the cell-0 enable; forced low in reset.
    assign pcm_rd_o = en_i & (cell_q == 7'd0) & ~rst_i;
    assign spdif_o  = spdif_q;

`ifdef SPDIF_TX_CHSTAT_EN
    // Channel status: one bit per frame for frames 0..23, zero afterwards.
    always_comb begin
        c_bit = 1'b0;
        if (frame_q < 8'd24) c_bit = CHSTAT[frame_q[4:0]];
    end
`else
    // Channel status disabled: C slot is constant zero.
    logic unused_chstat;
    assign unused_chstat = ^CHSTAT;
    always_comb begin
        c_bit = 1'b0;
    end
`endif

    // Select the shadowed sample of the current subframe, MSB-aligned to 24 bits.
    always_comb begin
        samp24 = '0;
        if (right) samp24 = 24'(shd_r_q) << PAD;
        else       samp24 = 24'(shd_l_q) << PAD;
    end

    // Logical value of the current slot (audio, V, U, C, P).
    always_comb begin
        slot_bit = 1'b0;
        if (slot >= 5'd4 && slot <= 5'd27) slot_bit = samp24[slot - 5'd4];
        else if (slot == 5'd30)            slot_bit = c_bit;
        else if (slot == 5'd31)            slot_bit = par_q;
    end

    // Preamble level for the current cell; polarity follows the line level
    // just before the preamble, captured at its first cell.
    always_comb begin
        pre_sel   = right ? PRE_W : ((frame_q == 8'd0) ? PRE_B : PRE_M);
        pre_inv_d = sub_start ? spdif_q : pre_inv_q;
        pre_lvl   = pre_sel[3'd7 - cell_q[2:0]] ^ pre_inv_d;
    end

    // Next line level and running parity over slots 4..30.
    always_comb begin
        spdif_d = spdif_q;
        par_d   = par_q;
        if (slot < 5'd4)       spdif_d = pre_lvl;
        else if (!cell_q[0])   spdif_d = ~spdif_q;
        else                   spdif_d = spdif_q ^ slot_bit;

        if (sub_start)                                  par_d = 1'b0;
        else if (!cell_q[0] && slot >= 5'd4 && slot <= 5'd30) par_d = par_q ^ slot_bit;
    end

    // Cell/frame counters, sample shadows and line register, all gated by en_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cell_q    <= '0;
            frame_q   <= '0;
            shd_l_q   <= '0;
            shd_r_q   <= '0;
            par_q     <= 1'b0;
            pre_inv_q <= 1'b0;
            spdif_q   <= 1'b0;
        end else if (en_i) begin
            cell_q    <= cell_q + 7'd1;
            par_q     <= par_d;
            pre_inv_q <= pre_inv_d;
            spdif_q   <= spdif_d;
            if (cell_q == 7'd127) begin
                frame_q <= (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
            end
            if (cell_q == 7'd0) begin
                shd_l_q <= pcm_l_i;
                shd_r_q <= pcm_r_i;
            end
        end
    end

endmodule
